matrix_scalar_engine: RTL and testbench

MATRIX_SCALAR_ENGINE -- requirements
Module: matrix_scalar_engine

---
 rtl/matrix_scalar_engine.sv | 144 ++++++++++++++
 tb/tb_matrix_scalar_engine.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scalar_engine.sv
// Multiplies an m x n sub-matrix by an unsigned scalar, one element per clock,
// with selectable wrap or saturate on products wider than ELEM_W.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the previous result
// RUN   | one element (row_q, col_q) written per cycle, row-major
// DONE  | single-cycle done pulse, then back to IDLE
module matrix_scalar_engine #(
   parameter int MAX_DIM  = 5,
   parameter int ELEM_W   = 8,
   parameter int SCALAR_W = 4,
   localparam int DIM_W   = $clog2(MAX_DIM + 1),
   localparam int MAT_W   = MAX_DIM * MAX_DIM * ELEM_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [DIM_W-1:0]    m,
   input  logic [DIM_W-1:0]    n,
   input  logic [SCALAR_W-1:0] scalar,
   input  logic                sat_en,
   input  logic [MAT_W-1:0]    matrix_in,
   output logic [MAT_W-1:0]    matrix_out,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic                overflow
);

   localparam int NUM_EL = MAX_DIM * MAX_DIM;
   localparam int IDX_W  = (NUM_EL > 1) ? $clog2(NUM_EL) : 1;
   localparam int PROD_W = ELEM_W + SCALAR_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state;
   logic [DIM_W-1:0]    m_q;
   logic [DIM_W-1:0]    n_q;
   logic [DIM_W-1:0]    row_q;
   logic [DIM_W-1:0]    col_q;
   logic [SCALAR_W-1:0] scalar_q;
   logic                sat_q;
   logic [MAT_W-1:0]    mat_q;
   logic [ELEM_W-1:0]   out_q [NUM_EL];
   logic [ELEM_W-1:0]   mat_elem [NUM_EL];

   logic                dim_bad;
   logic [IDX_W-1:0]    idx;
   logic [ELEM_W-1:0]   cur_elem;
   logic [PROD_W-1:0]   prod;
   logic                prod_ovf;
   logic [ELEM_W-1:0]   result;
   logic                last_col;
   logic                last_elem;

   for (genvar g = 0; g < NUM_EL; g++) begin : g_el
      assign mat_elem[g]                      = mat_q[g*ELEM_W +: ELEM_W];
      assign matrix_out[g*ELEM_W +: ELEM_W]   = out_q[g];
   end

   always_comb begin
      dim_bad   = (m == '0) || (n == '0) ||
                  (m > DIM_W'(MAX_DIM)) || (n > DIM_W'(MAX_DIM));
      idx       = IDX_W'(row_q) * IDX_W'(MAX_DIM) + IDX_W'(col_q);
      cur_elem  = mat_elem[idx];
      prod      = PROD_W'(cur_elem) * PROD_W'(scalar_q);
      prod_ovf  = |prod[PROD_W-1:ELEM_W];
      // Saturate clamps to all-ones; wrap keeps the low bits either way.
      result    = (sat_q && prod_ovf) ? '1 : prod[ELEM_W-1:0];
      last_col  = (col_q == n_q - DIM_W'(1));
      last_elem = last_col && (row_q == m_q - DIM_W'(1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         m_q      <= '0;
         n_q      <= '0;
         row_q    <= '0;
         col_q    <= '0;
         scalar_q <= '0;
         sat_q    <= 1'b0;
         mat_q    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         overflow <= 1'b0;
         for (int k = 0; k < NUM_EL; k++) out_q[k] <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  m_q      <= m;
                  n_q      <= n;
                  scalar_q <= scalar;
                  sat_q    <= sat_en;
                  mat_q    <= matrix_in;
                  row_q    <= '0;
                  col_q    <= '0;
                  overflow <= 1'b0;
                  err      <= dim_bad;
                  for (int k = 0; k < NUM_EL; k++) out_q[k] <= '0;
                  if (dim_bad) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end
            end
            RUN: begin
               out_q[idx] <= result;
               if (prod_ovf) overflow <= 1'b1;
               if (last_elem) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (last_col) begin
                  col_q <= '0;
                  row_q <= row_q + DIM_W'(1);
               end else begin
                  col_q <= col_q + DIM_W'(1);
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_scalar_engine.sv
// Bench for matrix_scalar_engine: directed cases plus random operations checked
// against an element-by-element arithmetic model.
module tb_matrix_scalar_engine;

   localparam int MAX_DIM = 5;
   localparam int ELEM_W  = 8;
   localparam int SCAL_W  = 4;
   localparam int DIM_W   = $clog2(MAX_DIM + 1);
   localparam int MAT_W   = MAX_DIM * MAX_DIM * ELEM_W;

   localparam int MAX2    = 3;
   localparam int ELEM2_W = 16;
   localparam int SCAL2_W = 8;
   localparam int DIM2_W  = $clog2(MAX2 + 1);
   localparam int MAT2_W  = MAX2 * MAX2 * ELEM2_W;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [DIM_W-1:0]  m = '0;
   logic [DIM_W-1:0]  n = '0;
   logic [SCAL_W-1:0] scalar = '0;
   logic              sat_en = 1'b0;
   logic [MAT_W-1:0]  matrix_in = '0;
   logic [MAT_W-1:0]  matrix_out;
   logic              busy, done, err, overflow;

   logic               start2 = 1'b0;
   logic [DIM2_W-1:0]  m2 = '0;
   logic [DIM2_W-1:0]  n2 = '0;
   logic [SCAL2_W-1:0] scalar2 = '0;
   logic               sat2 = 1'b0;
   logic [MAT2_W-1:0]  matrix_in2 = '0;
   logic [MAT2_W-1:0]  matrix_out2;
   logic               busy2, done2, err2, overflow2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   matrix_scalar_engine #(.MAX_DIM(MAX_DIM), .ELEM_W(ELEM_W), .SCALAR_W(SCAL_W)) dut (
      .clk(clk), .reset(reset), .start(start), .m(m), .n(n), .scalar(scalar),
      .sat_en(sat_en), .matrix_in(matrix_in), .matrix_out(matrix_out),
      .busy(busy), .done(done), .err(err), .overflow(overflow)
   );

   matrix_scalar_engine #(.MAX_DIM(MAX2), .ELEM_W(ELEM2_W), .SCALAR_W(SCAL2_W)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .m(m2), .n(n2), .scalar(scalar2),
      .sat_en(sat2), .matrix_in(matrix_in2), .matrix_out(matrix_out2),
      .busy(busy2), .done(done2), .err(err2), .overflow(overflow2)
   );

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic bit dim_invalid(input int mm, input int nn);
      return (mm == 0) || (nn == 0) || (mm > MAX_DIM) || (nn > MAX_DIM);
   endfunction

   // Expected result: each in-region element times scalar, wrapped or clamped.
   function automatic logic [MAT_W-1:0] model_out(input int mm, input int nn, input int sc,
                                                   input bit sat, input logic [MAT_W-1:0] mat);
      logic [MAT_W-1:0] res = '0;
      int e, p, r;
      if (dim_invalid(mm, nn)) return res;
      for (int i = 0; i < mm; i++)
         for (int j = 0; j < nn; j++) begin
            e = int'(mat[(i*MAX_DIM+j)*ELEM_W +: ELEM_W]);
            p = e * sc;
            r = sat ? ((p > 255) ? 255 : p) : (p % 256);
            res[(i*MAX_DIM+j)*ELEM_W +: ELEM_W] = r[ELEM_W-1:0];
         end
      return res;
   endfunction

   function automatic bit model_ovf(input int mm, input int nn, input int sc,
                                    input logic [MAT_W-1:0] mat);
      bit o = 1'b0;
      if (dim_invalid(mm, nn)) return 1'b0;
      for (int i = 0; i < mm; i++)
         for (int j = 0; j < nn; j++)
            if (int'(mat[(i*MAX_DIM+j)*ELEM_W +: ELEM_W]) * sc > 255) o = 1'b1;
      return o;
   endfunction

   function automatic logic [MAT_W-1:0] rand_mat();
      logic [MAT_W-1:0] r;
      for (int k = 0; k < MAX_DIM*MAX_DIM; k++) r[k*ELEM_W +: ELEM_W] = ELEM_W'($urandom_range(0, 255));
      return r;
   endfunction

   function automatic logic [MAT_W-1:0] fill_mat(input int v);
      logic [MAT_W-1:0] r;
      for (int k = 0; k < MAX_DIM*MAX_DIM; k++) r[k*ELEM_W +: ELEM_W] = ELEM_W'(v);
      return r;
   endfunction

   task automatic do_op(input string tag, input int mm, input int nn, input int sc,
                        input bit sat, input logic [MAT_W-1:0] mat, input bit disturb);
      logic [MAT_W-1:0] exp_out = model_out(mm, nn, sc, sat, mat);
      bit exp_ovf = model_ovf(mm, nn, sc, mat);
      bit exp_err = dim_invalid(mm, nn);
      int exp_lat = exp_err ? 0 : mm * nn;
      int cyc = 0;
      bit seen = 1'b0;
      @(posedge clk); #1;
      m = DIM_W'(mm); n = DIM_W'(nn); scalar = SCAL_W'(sc); sat_en = sat;
      matrix_in = mat; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (!seen && cyc <= 40) begin
         if (done) seen = 1'b1;
         else begin
            if (disturb) begin
               start = 1'($urandom_range(0, 1));
               matrix_in = rand_mat();
               m = DIM_W'($urandom_range(1, 5));
               n = DIM_W'($urandom_range(1, 5));
               scalar = SCAL_W'($urandom_range(0, 15));
               sat_en = ~sat_en;
            end
            @(posedge clk); #1;
            cyc++;
         end
      end
      start = 1'b0;
      chk({tag, "_done_seen"}, 256'(seen), 256'(1));
      if (seen) begin
         chk({tag, "_latency"}, 256'(cyc), 256'(exp_lat));
         chk({tag, "_out"}, 256'(matrix_out), 256'(exp_out));
         chk({tag, "_err"}, 256'(err), 256'(exp_err));
         chk({tag, "_ovf"}, 256'(overflow), 256'(exp_ovf));
         chk({tag, "_busy_in_done"}, 256'(busy), 256'(0));
         @(posedge clk); #1;
         chk({tag, "_done_one_cycle"}, 256'(done), 256'(0));
         chk({tag, "_out_hold"}, 256'(matrix_out), 256'(exp_out));
         chk({tag, "_err_hold"}, 256'(err), 256'(exp_err));
      end
   endtask

   initial begin
      logic [MAT_W-1:0] ramp;
      logic [MAT2_W-1:0] exp2;
      int cyc;
      bit seen, spurious;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_out", 256'(matrix_out), 256'(0));
      chk("rst_busy", 256'(busy), 256'(0));
      chk("rst_done", 256'(done), 256'(0));
      chk("rst_err", 256'(err), 256'(0));
      chk("rst_ovf", 256'(overflow), 256'(0));
      // reset must win over a simultaneous start
      start = 1'b1; m = 3'd1; n = 3'd1; scalar = 4'd1; matrix_in = fill_mat(7);
      @(posedge clk); #1;
      chk("rst_prio_busy", 256'(busy), 256'(0));
      start = 1'b0; reset = 1'b0;

      do_op("basic_2x3", 2, 3, 3, 1'b0, fill_mat(10), 1'b0);
      do_op("wrap_1x1", 1, 1, 15, 1'b0, fill_mat(200), 1'b0);
      chk("wrap_val", 256'(matrix_out[7:0]), 256'(8'hB8));
      do_op("sat_1x1", 1, 1, 15, 1'b1, fill_mat(200), 1'b0);
      chk("sat_val", 256'(matrix_out[7:0]), 256'(8'hFF));
      do_op("err_m0", 0, 3, 5, 1'b0, fill_mat(9), 1'b0);
      do_op("err_m6", 6, 5, 5, 1'b0, fill_mat(9), 1'b0);
      do_op("err_n7", 2, 7, 5, 1'b1, fill_mat(9), 1'b0);
      do_op("scalar0", 4, 5, 0, 1'b0, rand_mat(), 1'b0);

      for (int k = 0; k < 25; k++) ramp[k*ELEM_W +: ELEM_W] = ELEM_W'(k);
      do_op("full_5x5", 5, 5, 2, 1'b0, ramp, 1'b1);

      for (int t = 0; t < 30; t++)
         do_op($sformatf("rnd%0d", t), $urandom_range(0, 6), $urandom_range(0, 6),
               $urandom_range(0, 15), 1'($urandom_range(0, 1)), rand_mat(), 1'($urandom_range(0, 1)));

      // abort a 4x4 run with reset on its third RUN edge
      @(posedge clk); #1;
      m = 3'd4; n = 3'd4; scalar = 4'd15; sat_en = 1'b0; matrix_in = fill_mat(255); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("abort_busy_before", 256'(busy), 256'(1));
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort_out", 256'(matrix_out), 256'(0));
      chk("abort_busy", 256'(busy), 256'(0));
      chk("abort_ovf", 256'(overflow), 256'(0));
      chk("abort_err", 256'(err), 256'(0));
      spurious = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (done) spurious = 1'b1;
         @(posedge clk); #1;
      end
      chk("abort_no_done", 256'(spurious), 256'(0));
      do_op("after_abort", 3, 4, 7, 1'b1, rand_mat(), 1'b0);

      // wide-element instance, saturating
      @(posedge clk); #1;
      m2 = 2'd3; n2 = 2'd3; scalar2 = 8'd100; sat2 = 1'b1;
      for (int k = 0; k < 9; k++) matrix_in2[k*ELEM2_W +: ELEM2_W] = 16'd1000;
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      cyc = 0; seen = 1'b0;
      while (!seen && cyc <= 20) begin
         if (done2) seen = 1'b1;
         else begin @(posedge clk); #1; cyc++; end
      end
      for (int k = 0; k < 9; k++) exp2[k*ELEM2_W +: ELEM2_W] = 16'hFFFF;
      chk("p2_done_seen", 256'(seen), 256'(1));
      chk("p2_latency", 256'(cyc), 256'(9));
      chk("p2_out", 256'(matrix_out2), 256'(exp2));
      chk("p2_ovf", 256'(overflow2), 256'(1));
      chk("p2_err", 256'(err2), 256'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
